// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, types and popcount helper for the multi-port register file
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  // Widest vector popcount() accepts; callers zero-extend up to this.
  localparam int POP_MAX   = 256;

  typedef logic [XLEN_DEF-1:0]          reg_data_t;
  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - busy-bit scoreboard: reserve on issue, release on writeback, pending count
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic [NREGS-1:0]  busy,
  output logic              rsv_ok,
  output logic [AW:0]       pend_cnt
);

  logic [NREGS-1:0] busy_nxt;
  logic             rsv_zero;

  // Judged on pre-edge busy, so a register released this cycle is still refused.
  always_comb begin
    rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
    rsv_ok   = rsv_en && !busy[rsv_addr] && !rsv_zero;
  end

  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NWR; w++)
      if (wr_en[w]) busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
    // Reserve lands after release: the new owner is still in flight.
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= (AW+1)'(popcount(POP_MAX'(busy_nxt)));
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with scoreboard; REGFILE_BYPASS_EN adds same-cycle write forwarding
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                rsv_ok,
  output logic [AW:0]         pend_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy),
    .rsv_ok   (rsv_ok),
    .pend_cnt (pend_cnt)
  );

  // Ports are visited in ascending order so the highest-index writer wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && !((ZERO_REG != 0) && (wr_addr[w*AW +: AW] == '0)))
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
    end
  end

  always_comb begin : rd_mux
    logic [AW-1:0] ra;
    logic          zero;
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    zero    = 1'b0;
    for (int r = 0; r < NRD; r++) begin
      ra   = rd_addr[r*AW +: AW];
      zero = (ZERO_REG != 0) && (ra == '0);
      rd_data[r*XLEN +: XLEN] = zero ? '0 : regs[ra];
      rd_busy[r]              = !zero && busy[ra];
`ifdef REGFILE_BYPASS_EN
      // Forwarded data is final, so the register only stays busy if re-reserved now.
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && (wr_addr[w*AW +: AW] == ra) && !zero) begin
          rd_data[r*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
          rd_busy[r]              = rsv_ok && (rsv_addr == ra);
        end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - table-driven and randomized self-checking bench for regfile_mp (honours REGFILE_BYPASS_EN)
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ok;
  logic [AW:0]         pend_cnt;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .pend_cnt(pend_cnt)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  rda;
    logic [4:0]  rdb;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        b0;
    logic        b1;
    logic        ok;
    int          pc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [NREGS];
  bit          m_busy [NREGS];

  function automatic vec_t mk(logic r, logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                              logic [4:0] wa1, logic [31:0] wd1, logic re, logic [4:0] ra,
                              logic [4:0] rda, logic [4:0] rdb, logic [31:0] d0, logic [31:0] d1,
                              logic b0, logic b1, logic ok, int pc);
    vec_t v;
    v.rst = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.re = re; v.ra = ra; v.rda = rda; v.rdb = rdb;
    v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.ok = ok; v.pc = pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  // Reference read: register 0 is zero and never busy; bypass takes the highest-index writer.
  function automatic void m_read(input vec_t v, input logic [4:0] a, input logic ok,
                                 output logic [31:0] d, output logic b);
    d = (a == 0) ? 32'h0 : m_regs[a];
    b = (a != 0) && m_busy[a];
`ifdef REGFILE_BYPASS_EN
    if (a != 0) begin
      if (v.we[1] && v.wa1 == a) begin d = v.wd1; b = ok && (v.ra == a); end
      else if (v.we[0] && v.wa0 == a) begin d = v.wd0; b = ok && (v.ra == a); end
    end
`endif
  endfunction

  task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
    logic [31:0] e_d0, e_d1;
    logic        e_b0, e_b1, e_ok;
    int          e_pc;
    rst      = v.rst;
    wr_en    = v.we;
    wr_addr  = {v.wa1, v.wa0};
    wr_data  = {v.wd1, v.wd0};
    rsv_en   = v.re;
    rsv_addr = v.ra;
    rd_addr  = {v.rdb, v.rda};
    @(negedge clk);
    e_ok = v.re && !m_busy[v.ra] && (v.ra != 0);
    m_read(v, v.rda, e_ok, e_d0, e_b0);
    m_read(v, v.rdb, e_ok, e_d1, e_b1);
    if (use_tbl) begin
      chk({tag, " rd_data0"}, rd_data[31:0],  v.d0);
      chk({tag, " rd_data1"}, rd_data[63:32], v.d1);
      chk({tag, " rd_busy0"}, 32'(rd_busy[0]), 32'(v.b0));
      chk({tag, " rd_busy1"}, 32'(rd_busy[1]), 32'(v.b1));
      chk({tag, " rsv_ok"},   32'(rsv_ok),     32'(v.ok));
    end else begin
      chk({tag, " rd_data0"}, rd_data[31:0],  e_d0);
      chk({tag, " rd_data1"}, rd_data[63:32], e_d1);
      chk({tag, " rd_busy0"}, 32'(rd_busy[0]), 32'(e_b0));
      chk({tag, " rd_busy1"}, 32'(rd_busy[1]), 32'(e_b1));
      chk({tag, " rsv_ok"},   32'(rsv_ok),     32'(e_ok));
    end
    if (v.rst) begin
      for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    end else begin
      if (v.we[0] && v.wa0 != 0) m_regs[v.wa0] = v.wd0;
      if (v.we[1] && v.wa1 != 0) m_regs[v.wa1] = v.wd1;
      if (v.we[0]) m_busy[v.wa0] = 0;
      if (v.we[1]) m_busy[v.wa1] = 0;
      if (e_ok) m_busy[v.ra] = 1;
    end
    e_pc = use_tbl ? v.pc : m_count();
    @(posedge clk);
    #1;
    chk({tag, " pend_cnt"}, 32'(pend_cnt), 32'(e_pc));
  endtask

  vec_t tbl[$];
  vec_t hand[$];

  initial begin
    vec_t rv;
    rst = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rd_addr = '0;
    for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_busy[i] = 0; end

    //          rst we     wa0 wd0            wa1 wd1            re ra  rda rdb  d0             d1             b0 b1 ok pc
    tbl.push_back(mk(0, 2'b11, 1, 32'h11,       2, 32'h22,       1, 3,  3,  0,  32'h0,         32'h0,         0, 0, 1, 1));
    tbl.push_back(mk(0, 2'b01, 4, 32'h44,       0, 32'h0,        0, 0,  1,  3,  32'h11,        32'h0,         0, 1, 0, 1));
    tbl.push_back(mk(1, 2'b01, 6, 32'h66,       0, 32'h0,        1, 5,  4,  2,  32'h44,        32'h22,        0, 0, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  1,  6,  32'h0,         32'h0,         0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 5, 32'hDEADBEEF, 5, 32'h12345678, 0, 0,  0,  0,  32'h0,         32'h0,         0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 0, 32'hFFFFFFFF, 0, 32'h0,        1, 0,  5,  5,  32'h12345678,  32'h12345678,  0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  0,  5,  32'h0,         32'h12345678,  0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,        1, 7,  7,  7,  32'h0,         32'h0,         0, 0, 1, 1));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,        1, 7,  7,  7,  32'h0,         32'h0,         1, 1, 0, 1));
    tbl.push_back(mk(0, 2'b10, 0, 32'h0,        7, 32'h42,       0, 0,  5,  1,  32'h12345678,  32'h0,         0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,        1, 9,  7,  7,  32'h42,        32'h42,        0, 0, 1, 1));
    tbl.push_back(mk(0, 2'b01, 9, 32'h99,       0, 32'h0,        1, 9,  7,  5,  32'h42,        32'h12345678,  0, 0, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,        1, 9,  9,  7,  32'h99,        32'h42,        0, 0, 1, 1));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,        1, 10, 9,  7,  32'h99,        32'h42,        1, 0, 1, 2));
    tbl.push_back(mk(0, 2'b10, 0, 32'h0,        11, 32'h111,     1, 11, 9,  10, 32'h99,        32'h0,         1, 1, 1, 3));
    tbl.push_back(mk(0, 2'b11, 9, 32'h900,      10, 32'hA00,     0, 0,  11, 11, 32'h111,       32'h111,       1, 1, 0, 1));
    tbl.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,        0, 0,  9,  10, 32'h900,       32'hA00,       0, 0, 0, 1));

    // Read-after-write on x3: forwarded in the same cycle with bypass, one cycle later without.
`ifdef REGFILE_BYPASS_EN
    hand.push_back(mk(0, 2'b01, 3, 32'hA5A5A5A5, 0, 32'h0,  0, 0, 3, 11, 32'hA5A5A5A5, 32'h111,      0, 1, 0, 1));
    hand.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  0, 0, 3, 3,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 1));
    hand.push_back(mk(0, 2'b10, 0, 32'h0,        3, 32'h5A, 1, 3, 3, 3,  32'h5A,       32'h5A,       1, 1, 1, 2));
    hand.push_back(mk(0, 2'b01, 3, 32'h77,       0, 32'h0,  0, 0, 3, 3,  32'h77,       32'h77,       0, 0, 0, 1));
`else
    hand.push_back(mk(0, 2'b01, 3, 32'hA5A5A5A5, 0, 32'h0,  0, 0, 3, 11, 32'h0,        32'h111,      0, 1, 0, 1));
    hand.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  0, 0, 3, 3,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 1));
    hand.push_back(mk(0, 2'b10, 0, 32'h0,        3, 32'h5A, 1, 3, 3, 3,  32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 1, 2));
    hand.push_back(mk(0, 2'b01, 3, 32'h77,       0, 32'h0,  0, 0, 3, 3,  32'h5A,       32'h5A,       1, 1, 0, 1));
`endif
    hand.push_back(mk(0, 2'b00, 0, 32'h0,        0, 32'h0,  0, 0, 3, 11, 32'h77,       32'h111,      0, 1, 0, 1));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset pend_cnt", 32'(pend_cnt), 32'h0);
    chk("reset rd_busy", 32'(rd_busy), 32'h0);

    for (int i = 0; i < tbl.size(); i++)
      run_cycle(tbl[i], 1'b1, $sformatf("tbl[%0d]", i));
    for (int i = 0; i < hand.size(); i++)
      run_cycle(hand[i], 1'b1, $sformatf("raw[%0d]", i));

    for (int i = 0; i < 400; i++) begin
      rv = mk(0, 2'b00, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0);
      rv.rst = ($urandom_range(0, 63) == 0);
      rv.we  = 2'($urandom_range(0, 3));
      rv.wa0 = 5'($urandom_range(0, 7));
      rv.wa1 = 5'($urandom_range(0, 7));
      rv.wd0 = $urandom;
      rv.wd1 = $urandom;
      rv.re  = 1'($urandom_range(0, 1));
      rv.ra  = 5'($urandom_range(0, 7));
      rv.rda = 5'($urandom_range(0, 7));
      rv.rdb = 5'($urandom_range(0, 7));
      run_cycle(rv, 1'b0, $sformatf("rnd[%0d]", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
